// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/sub, DIGIT bits per clock, with carry/overflow/zero/negative flags and optional saturation
module seq_addsub #(
    parameter int WIDTH    = 8,
    parameter int DIGIT    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, sum_r, full, sat, res;
    logic [DIGIT:0]   slice;
    logic [CW-1:0]    cnt;
    logic             carry, a_sign, b_sign, take, last, ovf;
    assign busy = (state == BUSY);
    assign done = (state == DONE);
    // overflow from operand signs: same-sign inputs whose sum flips sign (equivalent to cin^cout at the MSB)
    always_comb begin
        take     = start && (state != BUSY);
        last     = (cnt == CW'(N - 1));
        slice    = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        full     = (sum_r >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        ovf      = (a_sign == b_sign) && (full[WIDTH-1] != a_sign);
        sat      = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        res      = (SATURATE != 0 && ovf) ? sat : full;
        state_nx = take ? BUSY : (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                a_r    <= a;
                b_r    <= op_sub ? ~b : b;
                sum_r  <= '0;
                cnt    <= '0;
                carry  <= op_sub;
                a_sign <= a[WIDTH-1];
                b_sign <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
            end else if (state == BUSY) begin
                a_r   <= a_r >> DIGIT;
                b_r   <= b_r >> DIGIT;
                sum_r <= full;
                cnt   <= cnt + CW'(1);
                carry <= slice[DIGIT];
                if (last) begin
                    result   <= res;
                    cout     <= slice[DIGIT];
                    overflow <= ovf;
                    zero     <= (res == '0);
                    negative <= res[WIDTH-1];
                end
            end
        end
    end
endmodule
